// File: rtl/ds_serial_deserialiser.sv
// ds_serial_deserialiser: three-lane MSB-first serial receiver with frame-abort detection.
// Optional C == A-B consistency check is built when DS_DESER_SUBTR_CHECK_EN is defined.
module ds_serial_deserialiser #(
  parameter int WIDTH     = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic                 ser_a,
  input  logic                 ser_b,
  input  logic                 ser_c,
  output logic [WIDTH-1:0]     word_a,
  output logic [WIDTH-1:0]     word_b,
  output logic [WIDTH-1:0]     word_c,
  output logic                 word_valid,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
`ifdef DS_DESER_SUBTR_CHECK_EN
  ,
  output logic                 subtr_mismatch
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_sh_a, r_sh_b, r_sh_c;
  logic [WIDTH-1:0]     r_word_a, r_word_b, r_word_c;
  logic                 r_word_valid;
  logic                 r_frame_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic                 w_start;
  logic                 w_shift;
  logic                 w_done;
  logic                 w_abort;
  logic [WIDTH-1:0]     w_nxt_a, w_nxt_b, w_nxt_c;

  assign w_nxt_a = {r_sh_a[WIDTH-2:0], ser_a};
  assign w_nxt_b = {r_sh_b[WIDTH-2:0], ser_b};
  assign w_nxt_c = {r_sh_c[WIDTH-2:0], ser_c};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A strobe seen while shifting is an abort that also starts the next frame.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_in) begin
          w_start     = 1'b1;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (valid_in) begin
          w_abort     = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = S_SHIFT;
        end else if (r_cnt == LAST_BIT) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_shift     = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= {CNT_W{1'b0}};
      r_sh_a       <= {WIDTH{1'b0}};
      r_sh_b       <= {WIDTH{1'b0}};
      r_sh_c       <= {WIDTH{1'b0}};
      r_word_a     <= {WIDTH{1'b0}};
      r_word_b     <= {WIDTH{1'b0}};
      r_word_c     <= {WIDTH{1'b0}};
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_cnt    <= {ERR_CNT_W{1'b0}};
    end else begin
      r_word_valid <= w_done;
      r_frame_err  <= w_abort;
      if (w_start) begin
        r_sh_a <= {{(WIDTH-1){1'b0}}, ser_a};
        r_sh_b <= {{(WIDTH-1){1'b0}}, ser_b};
        r_sh_c <= {{(WIDTH-1){1'b0}}, ser_c};
        r_cnt  <= CNT_W'(1);
      end else if (w_shift) begin
        r_sh_a <= w_nxt_a;
        r_sh_b <= w_nxt_b;
        r_sh_c <= w_nxt_c;
        r_cnt  <= r_cnt + CNT_W'(1);
      end else if (w_done) begin
        r_word_a <= w_nxt_a;
        r_word_b <= w_nxt_b;
        r_word_c <= w_nxt_c;
        r_sh_a   <= {WIDTH{1'b0}};
        r_sh_b   <= {WIDTH{1'b0}};
        r_sh_c   <= {WIDTH{1'b0}};
        r_cnt    <= {CNT_W{1'b0}};
      end
      if (w_abort && (r_err_cnt != ERR_MAX)) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

`ifdef DS_DESER_SUBTR_CHECK_EN
  logic [WIDTH-1:0] w_diff;
  logic             r_subtr_mismatch;

  assign w_diff = w_nxt_a - w_nxt_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_subtr_mismatch <= 1'b0;
    end else if (w_done) begin
      r_subtr_mismatch <= (w_nxt_c != w_diff);
    end
  end

  assign subtr_mismatch = r_subtr_mismatch;
`endif

  assign word_a     = r_word_a;
  assign word_b     = r_word_b;
  assign word_c     = r_word_c;
  assign word_valid = r_word_valid;
  assign frame_err  = r_frame_err;
  assign err_cnt    = r_err_cnt;
  assign busy       = (r_state == S_SHIFT);

endmodule

// File: tb/tb_ds_serial_deserialiser.sv
// Directed self-checking bench for ds_serial_deserialiser (WIDTH=16, ERR_CNT_W=8).
module tb_ds_serial_deserialiser;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        ser_a, ser_b, ser_c;
  logic [15:0] word_a, word_b, word_c;
  logic        word_valid;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic        busy;
`ifdef DS_DESER_SUBTR_CHECK_EN
  logic        subtr_mismatch;
`endif

  int tests = 0;
  int fails = 0;
  int wv_cnt = 0;
  int fe_cnt = 0;

  ds_serial_deserialiser #(.WIDTH(16), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .ser_a(ser_a), .ser_b(ser_b), .ser_c(ser_c),
    .word_a(word_a), .word_b(word_b), .word_c(word_c),
    .word_valid(word_valid), .frame_err(frame_err),
    .err_cnt(err_cnt), .busy(busy)
`ifdef DS_DESER_SUBTR_CHECK_EN
    , .subtr_mismatch(subtr_mismatch)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (word_valid === 1'b1) wv_cnt <= wv_cnt + 1;
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
  end

  task automatic drive_bit(input logic v, input logic a, input logic b, input logic c);
    valid_in = v; ser_a = a; ser_b = b; ser_c = c;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    for (int i = 15; i >= 0; i--) drive_bit(i == 15, a[i], b[i], c[i]);
    valid_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid_in = 1'b0; ser_a = 1'b0; ser_b = 1'b0; ser_c = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_words(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c);
    tests++;
    if (word_a !== a || word_b !== b || word_c !== c) begin
      fails++;
      $display("FAIL %s: got %h/%h/%h expected %h/%h/%h", name, word_a, word_b, word_c, a, b, c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_in = 1'b0; ser_a = 1'b1; ser_b = 1'b1; ser_c = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_words("reset_words", 16'h0000, 16'h0000, 16'h0000);
    tests++;
    if ({word_valid, frame_err, busy} !== 3'b000 || err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_flags: wv/fe/busy=%b%b%b err_cnt=%0d expected 000 and 0",
               word_valid, frame_err, busy, err_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    for (int i = 0; i < 4; i++) drive_bit(1'b0, i[0], ~i[0], i[1]);
    tests++;
    if (busy !== 1'b0 || wv_cnt !== 0) begin
      fails++;
      $display("FAIL idle_ignore: busy=%b wv_cnt=%0d expected 0 and 0", busy, wv_cnt);
    end
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_shift: got %b expected 1", busy);
    end
    do_reset();
    send_frame(16'h1234, 16'h0234, 16'h1000);
    tests++;
    if (word_valid !== 1'b1 || wv_cnt !== 0) begin
      fails++;
      $display("FAIL nominal_latency: word_valid=%b earlier pulses=%0d expected 1 and 0",
               word_valid, wv_cnt);
    end
    check_words("nominal_words", 16'h1234, 16'h0234, 16'h1000);
`ifdef DS_DESER_SUBTR_CHECK_EN
    tests++;
    if (subtr_mismatch !== 1'b0) begin
      fails++;
      $display("FAIL nominal_mismatch: got %b expected 0", subtr_mismatch);
    end
`endif
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (word_valid !== 1'b0 || busy !== 1'b0 || wv_cnt !== 1) begin
      fails++;
      $display("FAIL nominal_pulse: word_valid=%b busy=%b pulses=%0d expected 0 0 1",
               word_valid, busy, wv_cnt);
    end
  endtask

  task automatic test_mismatch();
    send_frame(16'h0001, 16'h0002, 16'hFFFF);
    check_words("wrap_words", 16'h0001, 16'h0002, 16'hFFFF);
`ifdef DS_DESER_SUBTR_CHECK_EN
    tests++;
    if (subtr_mismatch !== 1'b0) begin
      fails++;
      $display("FAIL wrap_mismatch: got %b expected 0", subtr_mismatch);
    end
`endif
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(16'h0001, 16'h0002, 16'hFFFE);
    check_words("bad_words", 16'h0001, 16'h0002, 16'hFFFE);
`ifdef DS_DESER_SUBTR_CHECK_EN
    tests++;
    if (subtr_mismatch !== 1'b1) begin
      fails++;
      $display("FAIL bad_mismatch: got %b expected 1", subtr_mismatch);
    end
    repeat (3) drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (subtr_mismatch !== 1'b1) begin
      fails++;
      $display("FAIL mismatch_hold: got %b expected 1", subtr_mismatch);
    end
`endif
  endtask

  task automatic test_abort();
    logic [15:0] a, b, c;
    int wv0;
    a = 16'hBEEF; b = 16'h0EEF; c = 16'hB000;
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
    wv0 = wv_cnt;
    for (int i = 15; i >= 6; i--) drive_bit(i == 15, 1'b1, 1'b0, 1'b1);
    drive_bit(1'b1, a[15], b[15], c[15]);
    tests++;
    if (frame_err !== 1'b1 || err_cnt !== 8'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_flag: frame_err=%b err_cnt=%0d busy=%b expected 1 1 1",
               frame_err, err_cnt, busy);
    end
    check_words("abort_hold", 16'h0001, 16'h0002, 16'hFFFE);
    for (int i = 14; i >= 0; i--) drive_bit(1'b0, a[i], b[i], c[i]);
    check_words("abort_next", 16'hBEEF, 16'h0EEF, 16'hB000);
    tests++;
    if (word_valid !== 1'b1 || fe_cnt !== 1 || wv_cnt !== wv0 || err_cnt !== 8'd1) begin
      fails++;
      $display("FAIL abort_counts: wv=%b fe_pulses=%0d wv_delta=%0d err_cnt=%0d expected 1 1 0 1",
               word_valid, fe_cnt, wv_cnt - wv0, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] fa [3];
    logic [15:0] fb [3];
    logic [15:0] fc [3];
    int wv0, fe0;
    fa[0] = 16'h00FF; fb[0] = 16'h000F; fc[0] = 16'h00F0;
    fa[1] = 16'hFFFF; fb[1] = 16'h0001; fc[1] = 16'hFFFE;
    fa[2] = 16'h8000; fb[2] = 16'h8000; fc[2] = 16'h0000;
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
    wv0 = wv_cnt; fe0 = fe_cnt;
    for (int k = 0; k < 3; k++) begin
      send_frame(fa[k], fb[k], fc[k]);
      tests++;
      if (word_valid !== 1'b1 || wv_cnt !== wv0 + k) begin
        fails++;
        $display("FAIL b2b_valid%0d: word_valid=%b pulses=%0d expected 1 %0d",
                 k, word_valid, wv_cnt - wv0, k);
      end
      check_words($sformatf("b2b_words%0d", k), fa[k], fb[k], fc[k]);
    end
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (fe_cnt !== fe0 || wv_cnt !== wv0 + 3) begin
      fails++;
      $display("FAIL b2b_counts: frame_err pulses=%0d word_valid pulses=%0d expected 0 3",
               fe_cnt - fe0, wv_cnt - wv0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int wv0, fe0;
    wv0 = wv_cnt; fe0 = fe_cnt;
    for (int i = 15; i >= 8; i--) drive_bit(i == 15, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0; valid_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_words("midrst_words", 16'h0000, 16'h0000, 16'h0000);
    tests++;
    if ({word_valid, frame_err, busy} !== 3'b000 || err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL midrst_flags: wv/fe/busy=%b%b%b err_cnt=%0d expected 000 and 0",
               word_valid, frame_err, busy, err_cnt);
    end
    repeat (10) drive_bit(1'b0, 1'b1, 1'b0, 1'b1);
    tests++;
    if (wv_cnt !== wv0 || fe_cnt !== fe0) begin
      fails++;
      $display("FAIL midrst_quiet: wv pulses=%0d fe pulses=%0d expected 0 0",
               wv_cnt - wv0, fe_cnt - fe0);
    end
    send_frame(16'hA5A5, 16'h5A5A, 16'h4B4B);
    check_words("midrst_next", 16'hA5A5, 16'h5A5A, 16'h4B4B);
  endtask

  task automatic test_saturation();
    int fe0;
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
    fe0 = fe_cnt;
    drive_bit(1'b1, 1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 300; n++) begin
      drive_bit(1'b0, 1'b0, 1'b1, 1'b0);
      drive_bit(1'b0, 1'b1, 1'b0, 1'b1);
      drive_bit(1'b1, 1'b1, 1'b1, 1'b0);
    end
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (err_cnt !== 8'd255 || fe_cnt !== fe0 + 300) begin
      fails++;
      $display("FAIL sat_count: err_cnt=%0d fe pulses=%0d expected 255 300",
               err_cnt, fe_cnt - fe0);
    end
    for (int n = 0; n < 5; n++) begin
      drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
      drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    end
    tests++;
    if (err_cnt !== 8'd255 || frame_err !== 1'b1) begin
      fails++;
      $display("FAIL sat_hold: err_cnt=%0d frame_err=%b expected 255 1", err_cnt, frame_err);
    end
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; ser_a = 1'b0; ser_b = 1'b0; ser_c = 1'b0;
    test_reset();
    test_nominal();
    test_mismatch();
    test_abort();
    test_back_to_back();
    test_reset_mid_frame();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
